// File: rtl/gemv_pkg.sv
// rtl/gemv_pkg.sv - shared widths, accumulator type and saturating add for the gemv engine
package gemv_pkg;

  localparam int DW_DEF    = 16;
  localparam int SZ_DEF    = 3;
  localparam int ACC_W_DEF = 40;

  typedef logic signed [ACC_W_DEF-1:0] acc_t;
  typedef logic signed [63:0]          wide_t;

  localparam acc_t ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
  localparam acc_t ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

  // Operands arrive sign-extended to 64 bits; callers keep the low w bits, so the
  // non-saturating path wraps mod 2^w simply by truncation.
  function automatic wide_t sat_add(input wide_t a, input wide_t b, input int unsigned w,
                                    input bit sat);
    logic signed [64:0] s;
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    s  = {a[63], a} + {b[63], b};
    hi = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo = -(65'sd1 <<< (w - 1));
    if (sat && (s > hi)) return hi[63:0];
    if (sat && (s < lo)) return lo[63:0];
    return s[63:0];
  endfunction

endpackage

// File: rtl/gemv_pe.sv
// rtl/gemv_pe.sv - one weight-stationary processing element with valid/last tag forwarding
module gemv_pe
  import gemv_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int SAT   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    w_load,
  input  logic signed [DW-1:0]    w_in,
  input  logic signed [DW-1:0]    x_in,
  input  logic signed [ACC_W-1:0] psum_in,
  input  logic                    v_in,
  input  logic                    last_in,
  output logic signed [ACC_W-1:0] psum_out,
  output logic                    v_out,
  output logic                    last_out
);

  logic signed [DW-1:0]    w_q, w_d;
  logic signed [ACC_W-1:0] psum_q, psum_d;
  logic                    v_q, v_d, last_q, last_d;
  logic signed [2*DW-1:0]  prod;
  wide_t                   term, sum;
  logic                    unused_hi;

  always_comb begin
    prod   = x_in * w_q;
    // In saturating mode the product is clamped before it joins the chain too.
    term   = sat_add(wide_t'(prod), '0, ACC_W, SAT != 0);
    sum    = sat_add(wide_t'(psum_in), term, ACC_W, SAT != 0);
    w_d    = w_load ? w_in : w_q;
    psum_d = psum_q;
    v_d    = v_q;
    last_d = last_q;
    if (en) begin
      psum_d = sum[ACC_W-1:0];
      v_d    = v_in;
      last_d = last_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q    <= '0;
      psum_q <= '0;
      v_q    <= 1'b0;
      last_q <= 1'b0;
    end else begin
      w_q    <= w_d;
      psum_q <= psum_d;
      v_q    <= v_d;
      last_q <= last_d;
    end
  end

  assign unused_hi = ^sum[63:ACC_W];
  assign psum_out  = psum_q;
  assign v_out     = v_q;
  assign last_out  = last_q;

endmodule

// File: rtl/gemv_systolic_engine.sv
// rtl/gemv_systolic_engine.sv - skewed 1-D systolic GEMV dot-product engine with row accumulation
module gemv_systolic_engine
  import gemv_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int SZ    = SZ_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int SAT   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               w_we,
  input  logic [SZ*DW-1:0]   w_data,
  output logic               w_ready,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SZ*DW-1:0]   in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_data,
  output logic               busy
);

  logic stall, in_fire, w_load;

  logic [DW-1:0] skew_q [SZ][SZ];
  logic [DW-1:0] skew_d [SZ][SZ];
  logic          iv_q, iv_d, il_q, il_d;

  logic signed [ACC_W-1:0] psum_c [SZ+1];
  logic [SZ:0]             v_c, l_c;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    act_q, act_d;
  logic [ACC_W-1:0]        od_q, od_d;
  logic                    ov_q, ov_d;
  wide_t                   acc_sum;
  logic                    unused_hi;

  assign stall     = ov_q & ~out_ready;
  assign in_ready  = ~stall & ~w_we;
  assign in_fire   = in_valid & in_ready;
  assign busy      = iv_q | act_q | (|v_c[SZ:1]);
  assign w_ready   = ~busy & ~ov_q;
  assign w_load    = w_we & w_ready;
  assign out_valid = ov_q;
  assign out_data  = od_q;

  // Lane k passes through k+1 stages so its element meets the psum at PE k.
  always_comb begin
    skew_d = skew_q;
    iv_d   = iv_q;
    il_d   = il_q;
    if (!stall) begin
      iv_d = in_fire;
      il_d = in_last;
      for (int k = 0; k < SZ; k++) begin
        skew_d[k][0] = in_data[k*DW +: DW];
        for (int s = 1; s < SZ; s++) skew_d[k][s] = skew_q[k][s-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SZ; k++)
        for (int s = 0; s < SZ; s++) skew_q[k][s] <= '0;
      iv_q <= 1'b0;
      il_q <= 1'b0;
    end else begin
      skew_q <= skew_d;
      iv_q   <= iv_d;
      il_q   <= il_d;
    end
  end

  assign psum_c[0] = '0;
  assign v_c[0]    = iv_q;
  assign l_c[0]    = il_q;

  for (genvar k = 0; k < SZ; k++) begin : g_pe
    gemv_pe #(.DW(DW), .ACC_W(ACC_W), .SAT(SAT)) u_pe (
      .clk      (clk),
      .rst      (rst),
      .en       (~stall),
      .w_load   (w_load),
      .w_in     (w_data[k*DW +: DW]),
      .x_in     (skew_q[k][k]),
      .psum_in  (psum_c[k]),
      .v_in     (v_c[k]),
      .last_in  (l_c[k]),
      .psum_out (psum_c[k+1]),
      .v_out    (v_c[k+1]),
      .last_out (l_c[k+1])
    );
  end

  always_comb begin
    acc_d   = acc_q;
    act_d   = act_q;
    od_d    = od_q;
    ov_d    = ov_q & ~out_ready;
    acc_sum = sat_add(act_q ? wide_t'(acc_q) : '0, wide_t'(psum_c[SZ]), ACC_W, SAT != 0);
    if (!stall && v_c[SZ]) begin
      if (l_c[SZ]) begin
        od_d  = acc_sum[ACC_W-1:0];
        ov_d  = 1'b1;
        acc_d = '0;
        act_d = 1'b0;
      end else begin
        acc_d = acc_sum[ACC_W-1:0];
        act_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      act_q <= 1'b0;
      od_q  <= '0;
      ov_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      act_q <= act_d;
      od_q  <= od_d;
      ov_q  <= ov_d;
    end
  end

  assign unused_hi = ^acc_sum[63:ACC_W];

endmodule
